// File: rtl/arb_pkg.sv
// Shared constants and state type for the arbitrated packet multiplexer.
package arb_pkg;

    localparam int unsigned N_CH  = 4;
    localparam int unsigned SEL_W = 2;

    typedef enum logic [0:0] {
        IDLE,
        XFER
    } state_e;

endpackage

// File: rtl/onehot_enc.sv
// Converts a 4-bit one-hot grant into a channel index.
// Also flags grants that have more than one bit set.
module onehot_enc
    import arb_pkg::*;
(
    input  logic [N_CH-1:0]  onehot,
    output logic [SEL_W-1:0] idx,
    output logic             multi_hot
);

    logic [N_CH-1:0] dec;

    always_comb begin
        idx = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (onehot[i]) begin
                idx = idx | SEL_W'(i);
            end
        end
        // Clearing the lowest set bit leaves a nonzero value only when two or more bits are set.
        dec       = onehot - {{(N_CH-1){1'b0}}, 1'b1};
        multi_hot = |(onehot & dec);
    end

endmodule

// File: rtl/arb_packet_mux.sv
// Forwards whole packets from one of four channels to a single registered output.
// An external round-robin arbiter picks the channel; grant is held off until the packet ends.
module arb_packet_mux
    import arb_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_CH-1:0]        in_valid,
    input  logic [N_CH*DATA_W-1:0] in_data,
    input  logic [N_CH-1:0]        in_last,
    output logic [N_CH-1:0]        in_ready,
    output logic [N_CH-1:0]        request,
    input  logic [N_CH-1:0]        grant,
    output logic                   out_valid,
    output logic [DATA_W-1:0]      out_data,
    output logic                   out_last,
    output logic [SEL_W-1:0]       out_src,
    input  logic                   out_ready,
    output logic [CNT_W-1:0]       pkt_count,
    output logic                   grant_err
);

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_last_q, out_last_d;
    logic [SEL_W-1:0]    out_src_q, out_src_d;
    logic [CNT_W-1:0]    pkt_count_q, pkt_count_d;
    logic                grant_err_q, grant_err_d;

    logic [SEL_W-1:0]    grant_idx;
    logic                grant_multi;
    logic [DATA_W-1:0]   sel_data;
    logic                accept;

    onehot_enc u_onehot_enc (
        .onehot    (grant),
        .idx       (grant_idx),
        .multi_hot (grant_multi)
    );

    assign sel_data = in_data[sel_q*DATA_W +: DATA_W];
    assign accept   = (state_q == XFER) && in_valid[sel_q] && in_ready[sel_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_src_q   <= '0;
            pkt_count_q <= '0;
            grant_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_src_q   <= out_src_d;
            pkt_count_q <= pkt_count_d;
            grant_err_q <= grant_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_src_d   = out_src_q;
        pkt_count_d = pkt_count_q;
        grant_err_d = grant_err_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (grant_multi) begin
                    grant_err_d = 1'b1;
                end else if (|(grant & in_valid)) begin
                    sel_d   = grant_idx;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (accept) begin
                    out_valid_d = 1'b1;
                    out_data_d  = sel_data;
                    out_last_d  = in_last[sel_q];
                    out_src_d   = sel_q;
                    if (in_last[sel_q]) begin
                        state_d     = IDLE;
                        pkt_count_d = pkt_count_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // rst_n gates request so the arbiter sees nothing while reset is held.
    always_comb begin
        request  = '0;
        in_ready = '0;
        if (state_q == IDLE && rst_n) begin
            request = in_valid;
        end
        if (state_q == XFER) begin
            in_ready[sel_q] = ~out_valid_q | out_ready;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_src   = out_src_q;
    assign pkt_count = pkt_count_q;
    assign grant_err = grant_err_q;

endmodule

// File: tb/tb_arb_packet_mux.sv
// Directed bench for arb_packet_mux; the bench drives grant in place of the external arbiter.
// Built with CNT_W=4 so counter wrap is reachable in a short run.
module tb_arb_packet_mux;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 4;

    logic              clk;
    logic              rst_n;
    logic [3:0]        in_valid;
    logic [4*DATA_W-1:0] in_data;
    logic [3:0]        in_last;
    logic [3:0]        in_ready;
    logic [3:0]        request;
    logic [3:0]        grant;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic [1:0]        out_src;
    logic              out_ready;
    logic [CNT_W-1:0]  pkt_count;
    logic              grant_err;

    int checks   = 0;
    int failures = 0;

    arb_packet_mux #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .request   (request),
        .grant     (grant),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src),
        .out_ready (out_ready),
        .pkt_count (pkt_count),
        .grant_err (grant_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int ch, input logic [DATA_W-1:0] val);
        in_data[ch*DATA_W +: DATA_W] = val;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        in_data   = '0;
        in_last   = 4'b0000;
        grant     = 4'b0000;
        out_ready = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_request",   32'(request),   32'h0);
        chk("rst_in_ready",  32'(in_ready),  32'h0);
        chk("rst_pkt_count", 32'(pkt_count), 32'h0);
        chk("rst_grant_err", 32'(grant_err), 32'h0);
        step();
        step();
        rst_n    = 1'b1;
        in_valid = 4'b0000;

        // Three-beat packet on channel 2 at full rate.
        in_valid = 4'b0100;
        set_data(2, 8'hA1);
        #1;
        chk("t1_idle_request",  32'(request),  32'h4);
        chk("t1_idle_in_ready", 32'(in_ready), 32'h0);
        step();
        chk("t1_no_grant_out_valid", 32'(out_valid), 32'h0);
        grant = 4'b0100;
        step();
        grant = 4'b0000;
        #1;
        chk("t1_xfer_request",  32'(request),  32'h0);
        chk("t1_xfer_in_ready", 32'(in_ready), 32'h4);
        step();
        chk("t1_a_valid", 32'(out_valid), 32'h1);
        chk("t1_a_data",  32'(out_data),  32'hA1);
        chk("t1_a_src",   32'(out_src),   32'h2);
        chk("t1_a_last",  32'(out_last),  32'h0);
        set_data(2, 8'hB2);
        step();
        chk("t1_b_data", 32'(out_data), 32'hB2);
        set_data(2, 8'hC3);
        in_last = 4'b0100;
        step();
        chk("t1_c_data",  32'(out_data),  32'hC3);
        chk("t1_c_last",  32'(out_last),  32'h1);
        chk("t1_pkt",     32'(pkt_count), 32'h1);
        chk("t1_back_idle_request", 32'(request), 32'h4);
        in_valid = 4'b0000;
        in_last  = 4'b0000;
        step();
        chk("t1_drain_valid", 32'(out_valid), 32'h0);

        // Backpressure on channel 1: output must hold while out_ready is low.
        in_valid = 4'b0010;
        grant    = 4'b0010;
        set_data(1, 8'h11);
        step();
        grant = 4'b0000;
        step();
        chk("t2_first_data", 32'(out_data), 32'h11);
        out_ready = 1'b0;
        set_data(1, 8'h22);
        #1;
        chk("t2_stall_in_ready", 32'(in_ready), 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t2_stall_data",  32'(out_data),  32'h11);
            chk("t2_stall_valid", 32'(out_valid), 32'h1);
        end
        out_ready = 1'b1;
        #1;
        chk("t2_resume_in_ready", 32'(in_ready), 32'h2);
        step();
        chk("t2_second_data", 32'(out_data), 32'h22);
        set_data(1, 8'h33);
        in_last = 4'b0010;
        step();
        chk("t2_third_data", 32'(out_data),  32'h33);
        chk("t2_pkt",        32'(pkt_count), 32'h2);
        in_valid = 4'b0000;
        in_last  = 4'b0000;
        step();

        // Grant on a channel that is not requesting is ignored silently.
        in_valid = 4'b0001;
        grant    = 4'b0100;
        step();
        chk("t3_still_idle_request", 32'(request),   32'h1);
        chk("t3_no_err",             32'(grant_err), 32'h0);
        chk("t3_no_out",             32'(out_valid), 32'h0);
        grant    = 4'b0000;
        in_valid = 4'b0000;

        // Single-beat packets from channels 0, 2, 3 in grant order; late grant change ignored.
        in_valid = 4'b1101;
        in_last  = 4'b1101;
        set_data(0, 8'h50);
        set_data(2, 8'h52);
        set_data(3, 8'h53);
        grant = 4'b0001;
        step();
        grant = 4'b0100;
        #1;
        chk("t4_x0_request",  32'(request),  32'h0);
        chk("t4_x0_in_ready", 32'(in_ready), 32'h1);
        step();
        chk("t4_p0_data", 32'(out_data), 32'h50);
        chk("t4_p0_src",  32'(out_src),  32'h0);
        chk("t4_idle_request", 32'(request), 32'hD);
        step();
        chk("t4_x2_request", 32'(request),   32'h0);
        chk("t4_x2_gap",     32'(out_valid), 32'h0);
        grant = 4'b1000;
        step();
        chk("t4_p2_data", 32'(out_data), 32'h52);
        chk("t4_p2_src",  32'(out_src),  32'h2);
        step();
        chk("t4_x3_request", 32'(request), 32'h0);
        grant = 4'b0000;
        step();
        chk("t4_p3_data", 32'(out_data),  32'h53);
        chk("t4_p3_src",  32'(out_src),   32'h3);
        chk("t4_pkt",     32'(pkt_count), 32'h5);
        in_valid = 4'b0000;
        in_last  = 4'b0000;

        // Multi-hot grant: no transfer, sticky error.
        in_valid = 4'b0011;
        grant    = 4'b0011;
        step();
        chk("t5_err_set",      32'(grant_err), 32'h1);
        chk("t5_idle_request", 32'(request),   32'h3);
        chk("t5_in_ready",     32'(in_ready),  32'h0);
        grant    = 4'b0000;
        in_valid = 4'b0000;
        step();
        chk("t5_err_sticky", 32'(grant_err), 32'h1);
        chk("t5_no_out",     32'(out_valid), 32'h0);

        // Reset during the second beat of a channel 3 packet.
        in_valid = 4'b1000;
        grant    = 4'b1000;
        set_data(3, 8'h61);
        step();
        grant = 4'b0000;
        step();
        chk("t6_beat1_data", 32'(out_data), 32'h61);
        set_data(3, 8'h62);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid",    32'(out_valid), 32'h0);
        chk("t6_rst_data",     32'(out_data),  32'h0);
        chk("t6_rst_src",      32'(out_src),   32'h0);
        chk("t6_rst_last",     32'(out_last),  32'h0);
        chk("t6_rst_pkt",      32'(pkt_count), 32'h0);
        chk("t6_rst_err",      32'(grant_err), 32'h0);
        chk("t6_rst_request",  32'(request),   32'h0);
        chk("t6_rst_in_ready", 32'(in_ready),  32'h0);
        step();
        rst_n    = 1'b1;
        in_valid = 4'b0010;
        grant    = 4'b0010;
        set_data(1, 8'h71);
        step();
        grant = 4'b0000;
        step();
        chk("t6_new_data", 32'(out_data), 32'h71);
        chk("t6_new_src",  32'(out_src),  32'h1);
        set_data(1, 8'h72);
        in_last = 4'b0010;
        step();
        chk("t6_new_last_data", 32'(out_data),  32'h72);
        chk("t6_new_pkt",       32'(pkt_count), 32'h1);
        in_valid = 4'b0000;
        in_last  = 4'b0000;

        // Fifteen more single-beat packets take the 4-bit counter from 1 through wrap to 0.
        in_valid = 4'b0001;
        in_last  = 4'b0001;
        grant    = 4'b0001;
        for (int i = 0; i < 15; i++) begin
            set_data(0, 8'(8'h80 + i));
            step();
            step();
            chk("t7_data", 32'(out_data),  32'(8'h80 + i));
            chk("t7_pkt",  32'(pkt_count), 32'((2 + i) % 16));
        end
        chk("t7_wrapped", 32'(pkt_count), 32'h0);
        in_valid = 4'b0000;
        in_last  = 4'b0000;
        grant    = 4'b0000;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/arb_packet_mux.md
ARB_PACKET_MUX -- requirements
Module: arb_packet_mux

Interface
REQ-001 SHALL have parameter DATA_W, default 8, payload width per channel.
REQ-002 SHALL have parameter CNT_W, default 16, width of packet counter.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  4  per-channel beat valid.
REQ-006 SHALL have port in_data  input  4*DATA_W  channel i at bits [i*DATA_W +: DATA_W].
REQ-007 SHALL have port in_last  input  4  per-channel end-of-packet marker.
REQ-008 SHALL have port in_ready  output  4  per-channel beat accept.
REQ-009 SHALL have port request  output  4  to round_robin_arbiter request.
REQ-010 SHALL have port grant  input  4  from round_robin_arbiter grant, one-hot or zero.
REQ-011 SHALL have port out_valid, out_data, out_last  output  1/DATA_W/1  registered output beat.
REQ-012 SHALL have port out_src  output  2  channel index of current out beat.
REQ-013 SHALL have port out_ready  input  1  downstream accept.
REQ-014 SHALL have port pkt_count  output  CNT_W  completed packets forwarded.
REQ-015 SHALL have port grant_err  output  1  sticky protocol-error flag.

Function
REQ-016 SHALL implement states IDLE and XFER; reset state IDLE.
REQ-017 SHALL drive request = in_valid in IDLE, 4'b0000 in XFER (arbiter cannot rotate mid-packet).
REQ-018 In IDLE, grant one-hot with grant & in_valid nonzero SHALL latch sel = index(grant) and go to XFER next cycle.
REQ-019 In IDLE, grant multi-hot SHALL be ignored, stay IDLE, set grant_err.
REQ-020 In IDLE, grant one-hot on a channel with in_valid low SHALL be ignored without error.
REQ-021 In IDLE, in_ready SHALL be 4'b0000.
REQ-022 In XFER, in_ready[sel] = ~out_valid | out_ready; all other in_ready bits 0.
REQ-023 Input beat accepted when in_valid[sel] & in_ready[sel]; SHALL load out_data/out_last/out_src and set out_valid next edge (latency 1 cycle).
REQ-024 out_valid SHALL clear when out_ready high and no beat accepted same cycle.
REQ-025 out_data/out_last/out_src SHALL hold stable while out_valid & ~out_ready.
REQ-026 Accepted beat with in_last SHALL return to IDLE next cycle and increment pkt_count by 1.
REQ-027 pkt_count SHALL wrap from 2^CNT_W-1 to 0 without flag.
REQ-028 Full throughput: with out_ready held high, one beat per cycle within a packet.
REQ-029 Single-beat packet (in_valid & in_last on first beat) SHALL be legal.
REQ-030 Minimum gap between last beat of one packet and first beat of next SHALL be 2 cycles (request re-assert, grant return).
REQ-031 grant changes during XFER SHALL be ignored.

Reset
REQ-032 rst_n low SHALL immediately force state IDLE, sel 0, out_valid 0, out_data 0, out_last 0, out_src 0, pkt_count 0, grant_err 0, in_ready 0, request 0.
REQ-033 Reset mid-packet SHALL drop the in-flight packet; no partial completion counted.
REQ-034 grant_err SHALL clear only on reset.

Structure
REQ-035 Package arb_pkg SHALL hold N_CH=4, SEL_W=2 and the state enum {IDLE, XFER}.
REQ-036 One sub-module onehot_enc (4-bit one-hot to 2-bit index plus multi-hot detect) SHALL be instantiated.
REQ-037 No other sub-modules; arbiter external, paired with this block at top level.

Verification
REQ-038 in_valid=4'b0100, grant=4'b0100 next cycle, 3 beats A,B,C last on C, out_ready=1 -> out_data A,B,C consecutive, out_src=2, pkt_count=1, state IDLE after C.
REQ-039 in_valid=4'b1101 held, arbiter grants 0 then 2 then 3 -> packets forwarded in order 0,2,3, request=0 during every XFER, pkt_count=3.
REQ-040 out_ready low for 3 cycles mid-packet -> out_data stable, in_ready[sel]=0, no beat lost or duplicated.
REQ-041 grant=4'b0011 in IDLE -> no transfer, grant_err=1 and remains 1 until rst_n low.
REQ-042 rst_n low during beat 2 of 4 -> all outputs 0 immediately; after release, new packet forwarded normally, pkt_count counts from 0.
REQ-043 pkt_count preset path: 2^CNT_W packets (CNT_W=4 build) -> pkt_count wraps to 0.
